// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command front end for the 4-bit combinational ALU.
// Accepts commands over valid/ready and reads operands from a small register file.
// It drives the ALU, writes the result back and returns it on a response channel.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds registered rsp_zero / rsp_carry outputs.
module alu_cmd_sequencer #(
    parameter int REG_COUNT = 4,
    localparam int RIDX_W = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [RIDX_W-1:0] cmd_src_a,
    input  logic [RIDX_W-1:0] cmd_src_b,
    input  logic [RIDX_W-1:0] cmd_dst,
    input  logic [3:0]        cmd_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [3:0]        rsp_data,
    output logic [RIDX_W-1:0] rsp_dst,
`ifdef ALU_SEQ_FLAGS_EN
    output logic              rsp_zero,
    output logic              rsp_carry,
`endif
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [2:0]        alu_sel,
    input  logic [3:0]        alu_result,
    output logic              busy
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;
    logic [3:0]        rsp_data_q, rsp_data_d;
    logic [RIDX_W-1:0] rsp_dst_q, rsp_dst_d;
    logic [3:0]        alu_a_q, alu_a_d;
    logic [3:0]        alu_b_q, alu_b_d;
    logic [2:0]        alu_sel_q, alu_sel_d;
    logic [3:0]        regs_q [REG_COUNT];
    logic [3:0]        regs_d [REG_COUNT];
    logic              accept;

`ifdef ALU_SEQ_FLAGS_EN
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              exec_carry;

    // Carry/borrow of the operation currently latched on the ALU inputs.
    always_comb begin
        exec_carry = 1'b0;
        if (alu_sel_q == OP_ADD) begin
            exec_carry = (5'(alu_a_q) + 5'(alu_b_q)) > 5'd15;
        end else if (alu_sel_q == OP_SUB) begin
            exec_carry = alu_a_q < alu_b_q;
        end
    end
`endif

    assign accept = cmd_valid && cmd_ready_q;

    // Next-state, register-file write-back and output-register updates.
    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_dst_d  = rsp_dst_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        regs_d     = regs_q;
`ifdef ALU_SEQ_FLAGS_EN
        rsp_zero_d  = rsp_zero_q;
        rsp_carry_d = rsp_carry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rsp_dst_d = cmd_dst;
                    if (cmd_op == OP_LOAD) begin
                        // LOAD bypasses the ALU and leaves its inputs untouched.
                        regs_d[cmd_dst] = cmd_imm;
                        rsp_data_d      = cmd_imm;
`ifdef ALU_SEQ_FLAGS_EN
                        rsp_zero_d  = (cmd_imm == 4'd0);
                        rsp_carry_d = 1'b0;
`endif
                        state_d = S_RESP;
                    end else begin
                        alu_a_d   = regs_q[cmd_src_a];
                        alu_b_d   = regs_q[cmd_src_b];
                        alu_sel_d = cmd_op;
                        state_d   = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                // Operands were latched at accept, so aliasing dst with a source is safe.
                rsp_data_d         = alu_result;
                regs_d[rsp_dst_q]  = alu_result;
`ifdef ALU_SEQ_FLAGS_EN
                rsp_zero_d  = (alu_result == 4'd0);
                rsp_carry_d = exec_carry;
`endif
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
    end

    // State, output and register-file storage; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_data_q  <= '0;
            rsp_dst_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
`ifdef ALU_SEQ_FLAGS_EN
            rsp_zero_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            rsp_data_q  <= rsp_data_d;
            rsp_dst_q   <= rsp_dst_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            regs_q      <= regs_d;
`ifdef ALU_SEQ_FLAGS_EN
            rsp_zero_q  <= rsp_zero_d;
            rsp_carry_q <= rsp_carry_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_dst   = rsp_dst_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign rsp_zero  = rsp_zero_q;
    assign rsp_carry = rsp_carry_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: directed and random commands checked against a
// register-file / ALU reference model; honours ALU_SEQ_FLAGS_EN for the flag outputs.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [1:0] cmd_src_a = '0;
    logic [1:0] cmd_src_b = '0;
    logic [1:0] cmd_dst = '0;
    logic [3:0] cmd_imm = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_data;
    logic [1:0] rsp_dst;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_sel;
    logic       busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic       rsp_zero, rsp_carry;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state
    int mregs [4];
    int last_a = 0, last_b = 0, last_sel = 0;
    int last_exp = 0;

    // ALU behaviour: 0 add, 1 sub, 2 and, 3 or, 4 xor, others return 0.
    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % 16;
            1: return (a - b + 16) % 16;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_carry(input int op, input int a, input int b);
        if (op == 0) return (a + b > 15) ? 1 : 0;
        if (op == 1) return (a < b) ? 1 : 0;
        return 0;
    endfunction

    assign alu_result = 4'(ref_alu(int'(alu_sel), int'(alu_a), int'(alu_b)));

    alu_cmd_sequencer #(.REG_COUNT(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_dst(rsp_dst),
`ifdef ALU_SEQ_FLAGS_EN
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_dst"}, rsp_dst, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_sel"}, alu_sel, 0);
        check({tag, "_busy"}, busy, 0);
`ifdef ALU_SEQ_FLAGS_EN
        check({tag, "_rsp_zero"}, rsp_zero, 0);
        check({tag, "_rsp_carry"}, rsp_carry, 0);
`endif
    endtask

    // Issue one command from IDLE and check its full life cycle at the expected edges.
    // With hold set, rsp_ready stays low and the task returns with the response pending.
    task automatic issue(input int op, input int sa, input int sb, input int dst,
                         input int imm, input bit hold);
        int va, vb, exp, expc;
        @(negedge clk);
        check("cmd_ready_before_accept", cmd_ready, 1);
        cmd_op = 3'(op); cmd_src_a = 2'(sa); cmd_src_b = 2'(sb);
        cmd_dst = 2'(dst); cmd_imm = 4'(imm);
        cmd_valid = 1'b1;
        rsp_ready = !hold;
        va = mregs[sa];
        vb = mregs[sb];
        if (op == 7) begin
            exp = imm; expc = 0;
        end else begin
            exp = ref_alu(op, va, vb); expc = ref_carry(op, va, vb);
            last_a = va; last_b = vb; last_sel = op;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        mregs[dst] = exp;
        last_exp = exp;
        check("cmd_ready_after_accept", cmd_ready, 0);
        check("busy_after_accept", busy, 1);
        check("alu_a_latched", alu_a, 32'(last_a));
        check("alu_b_latched", alu_b, 32'(last_b));
        check("alu_sel_latched", alu_sel, 32'(last_sel));
        if (op != 7) begin
            check("rsp_valid_during_exec", rsp_valid, 0);
            @(posedge clk); #1;
        end
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, 32'(exp));
        check("rsp_dst", rsp_dst, 32'(dst));
`ifdef ALU_SEQ_FLAGS_EN
        check("rsp_zero", rsp_zero, (exp == 0) ? 1 : 0);
        check("rsp_carry", rsp_carry, 32'(expc));
`endif
        if (!hold) begin
            @(posedge clk); #1;
            check("rsp_valid_after_handshake", rsp_valid, 0);
            check("cmd_ready_after_handshake", cmd_ready, 1);
            check("busy_after_handshake", busy, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mregs[i] = 0;

        // Reset held: every output at its reset value
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset_hold");
        @(negedge clk);
        rst = 1'b0;
        #1 check("cmd_ready_before_first_edge", cmd_ready, 0);
        @(posedge clk); #1;
        check("cmd_ready_first_edge", cmd_ready, 1);

        // Directed scenarios
        issue(7, 0, 0, 1, 9, 0);          // LOAD r1 = 9
        issue(7, 0, 0, 2, 5, 0);          // LOAD r2 = 5
        issue(0, 1, 2, 3, 0, 0);          // ADD r3 = 9 + 5 = E
        issue(0, 1, 1, 3, 0, 0);          // ADD r3 = 9 + 9 = 2, carry
        issue(1, 2, 1, 0, 0, 0);          // SUB r0 = 5 - 9 = C, borrow
        issue(4, 0, 0, 0, 0, 0);          // XOR r0 = 0, zero

        // Backpressure: response held while new commands are pulsed and ignored
        issue(2, 1, 2, 0, 0, 1);          // AND r0 = 9 & 5 = 1, response pending
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_valid = (i % 2 == 0);
            cmd_op = 3'b111; cmd_dst = 2'd2; cmd_imm = 4'hF;
            @(posedge clk); #1;
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, 32'(last_exp));
            check("bp_cmd_ready", cmd_ready, 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rsp_valid_released", rsp_valid, 0);
        check("bp_cmd_ready_released", cmd_ready, 1);
        issue(3, 2, 2, 3, 0, 0);          // OR r3 = r2: ignored LOAD must not have landed

        // Reserved op forwarded to ALU, result 0 written back
        issue(5, 1, 2, 1, 0, 0);
        issue(3, 1, 1, 2, 0, 0);          // read back r1 through OR
        issue(6, 3, 0, 3, 0, 0);

        // Randomized commands against the model
        for (int n = 0; n < 40; n++) begin
            issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), 0);
        end

        // Reset while a response is pending
        issue(7, 0, 0, 2, 7, 0);
        issue(7, 0, 0, 1, 11, 0);
        issue(0, 1, 2, 3, 0, 1);          // response pending, r3 already written
        #3 rst = 1'b1;
        #1 check_reset_outputs("reset_in_resp");
        for (int i = 0; i < 4; i++) mregs[i] = 0;
        last_a = 0; last_b = 0; last_sel = 0;
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1 check("cmd_ready_after_rerelease", cmd_ready, 0);
        @(posedge clk); #1;
        check("cmd_ready_edge_after_rerelease", cmd_ready, 1);
        issue(0, 0, 0, 0, 0, 0);          // ADD r0 + r0 = 0
        issue(3, 1, 2, 0, 0, 0);          // OR r1 | r2 = 0 after reset
        issue(3, 3, 3, 1, 0, 0);          // r3 cleared as well

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
